mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one external memory port between the instruction cache and the data cache system-side miss/write-through interfaces. It sits between the two `cache` instances and the SoC memory bus, serialising their transactions. It registers every memory-side output and returns read data with a one-cycle response pulse. A watchdog terminates hung transactions.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one external memory port between the
// instruction cache and the data cache. One transaction is in flight at a
// time: IDLE selects an owner and latches its request, BUSY waits for the
// memory (guarded by a watchdog), and RESP pulses the owner's ready.
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_strobe,
    input  logic              i_rw,
    input  logic [31:0]       i_address,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_ready,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [31:0]       d_address,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_ready,
    output logic              mem_enable,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_ready,
    output logic              grant_d,
    output logic              busy,
    output logic              timeout_error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]        state;
    logic              rw_q;
    logic [7:0]        count;
    logic [DATA_W-1:0] resp_data;
    logic              pick_d;

    // Only the low ADDR_W address bits reach the memory bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_address[31:ADDR_W], d_address[31:ADDR_W]};

    // D wins when it is the only requester, or on a tie when I owned the bus last.
    always_comb begin
        pick_d = d_strobe & (~i_strobe | ~grant_d);
    end

    // Sequence one transaction at a time: select and latch, wait for memory, respond.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_d       <= 1'b0;
            rw_q          <= 1'b0;
            mem_address   <= '0;
            mem_in        <= '0;
            count         <= 8'd0;
            resp_data     <= '0;
            timeout_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_strobe || d_strobe) begin
                        grant_d     <= pick_d;
                        rw_q        <= pick_d ? d_rw : i_rw;
                        mem_address <= pick_d ? d_address[ADDR_W-1:0] : i_address[ADDR_W-1:0];
                        mem_in      <= pick_d ? d_data_in : i_data_in;
                        count       <= 8'd0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        resp_data <= rw_q ? mem_out : '0;
                        state     <= RESP;
                    end else if (count == TIMEOUT_CNT) begin
                        resp_data     <= '0;
                        timeout_error <= 1'b1;
                        state         <= RESP;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so no input reaches an output combinationally.
    always_comb begin
        busy       = (state != IDLE);
        mem_enable = (state == BUSY);
        mem_read   = mem_enable & rw_q;
        mem_write  = mem_enable & ~rw_q;
        i_ready    = (state == RESP) & ~grant_d;
        d_ready    = (state == RESP) & grant_d;
        i_data_out = i_ready ? resp_data : '0;
        d_data_out = d_ready ? resp_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Requests are pushed into an ordered
// scoreboard when driven; a per-cycle monitor plays the memory, checks the
// memory-side bus against the queue head and pops it on each ready pulse.
module tb_mem_arbiter;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clock;
    logic              reset;
    logic              i_strobe, i_rw, i_ready;
    logic [31:0]       i_address;
    logic [DATA_W-1:0] i_data_in, i_data_out;
    logic              d_strobe, d_rw, d_ready;
    logic [31:0]       d_address;
    logic [DATA_W-1:0] d_data_in, d_data_out;
    logic              mem_enable, mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in, mem_out;
    logic              mem_ready;
    logic              grant_d, busy, timeout_error;

    typedef struct {
        bit          is_d;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    txn_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc0;
    int en_cyc, mr_cyc, wait_cnt;
    int last_en_cyc, last_ready_cyc;
    int last_i_cyc, last_d_cyc, cont_n, seq;
    bit seen_en, prev_ready, last_ready_d;
    bit rep_i, rep_d, cont_mode, exp_terr;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .i_strobe(i_strobe), .i_rw(i_rw), .i_address(i_address), .i_data_in(i_data_in),
        .i_data_out(i_data_out), .i_ready(i_ready),
        .d_strobe(d_strobe), .d_rw(d_rw), .d_address(d_address), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_ready(d_ready),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out), .mem_ready(mem_ready),
        .grant_d(grant_d), .busy(busy), .timeout_error(timeout_error)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=running required=finished");
        $fatal(1, "[TB] simulation exceeded time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({mem_enable, mem_read, mem_write, busy, grant_d,
                                          timeout_error, i_ready, d_ready}), 32'h0);
        checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'h0);
        checkOutput({tag, "_mem_in"}, mem_in, 32'h0);
        checkOutput({tag, "_i_data_out"}, i_data_out, 32'h0);
        checkOutput({tag, "_d_data_out"}, d_data_out, 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic applyStimulus(input bit is_d, input bit rw, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        txn_t t;
        t.is_d  = is_d;
        t.rw    = rw;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rdata;
        t.lat   = lat;
        sb.push_back(t);
        if (is_d) begin
            d_rw = rw; d_address = addr; d_data_in = wdata; d_strobe = 1'b1;
        end else begin
            i_rw = rw; i_address = addr; i_data_in = wdata; i_strobe = 1'b1;
        end
    endtask

    task automatic next_request(input bit is_d);
        seq++;
        applyStimulus(is_d, seq[0], 32'h0000_0100 + 32'(seq * 4) + (is_d ? 32'h800 : 32'h0),
                      $urandom, $urandom, 0);
    endtask

    // One cycle of monitoring: bus checks, ready checks with scoreboard pop,
    // requester strobe release, and the memory model's response.
    task automatic monitor_cycle();
        txn_t h;
        bit rdy;
        rdy = (i_ready === 1'b1) || (d_ready === 1'b1);
        if (mem_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("enable_without_request", 32'(mem_enable), 32'h0);
            end else begin
                h = sb[0];
                if (!seen_en) begin
                    seen_en = 1'b1; en_cyc = cyc; last_en_cyc = cyc; wait_cnt = 0;
                    checkOutput("grant_d", 32'(grant_d), 32'(h.is_d));
                    if (!h.rw) checkOutput("mem_in", mem_in, h.wdata);
                end
                checkOutput("mem_address", 32'(mem_address), 32'(h.addr[ADDR_W-1:0]));
                checkOutput("mem_read", 32'(mem_read), 32'(h.rw));
                checkOutput("mem_write", 32'(mem_write), 32'(!h.rw));
            end
        end
        if (rdy) begin
            checkOutput("ready_single_cycle", 32'(prev_ready), 32'h0);
            checkOutput("ready_both", 32'(i_ready & d_ready), 32'h0);
            if (sb.size() == 0) begin
                checkOutput("ready_unexpected", 32'(rdy), 32'h0);
            end else begin
                h = sb.pop_front();
                checkOutput("ready_owner_d", 32'(d_ready), 32'(h.is_d));
                if (h.lat < 0) begin
                    exp_terr = 1'b1;
                    checkOutput("timeout_ready_cycle", 32'(cyc), 32'(en_cyc + TIMEOUT + 1));
                end else begin
                    checkOutput("ready_cycle", 32'(cyc), 32'(mr_cyc + 1));
                end
                checkOutput("data_out", h.is_d ? d_data_out : i_data_out,
                            (h.rw && h.lat >= 0) ? h.rdata : 32'h0);
                checkOutput("timeout_error", 32'(timeout_error), 32'(exp_terr));
                if (cont_mode) begin
                    if (cont_n > 0) checkOutput("alternate", 32'(d_ready), 32'(!last_ready_d));
                    if (h.is_d) begin
                        if (last_d_cyc > 0) checkOutput("d_gap_le_8", 32'((cyc - last_d_cyc) <= 8), 32'h1);
                        last_d_cyc = cyc;
                    end else begin
                        if (last_i_cyc > 0) checkOutput("i_gap_le_8", 32'((cyc - last_i_cyc) <= 8), 32'h1);
                        last_i_cyc = cyc;
                    end
                    cont_n++;
                end
                last_ready_d   = h.is_d;
                last_ready_cyc = cyc;
                seen_en        = 1'b0;
                if (h.is_d) begin
                    d_strobe = 1'b0;
                    if (rep_d) next_request(1'b1);
                end else begin
                    i_strobe = 1'b0;
                    if (rep_i) next_request(1'b0);
                end
            end
        end
        prev_ready = rdy;
        mem_ready  = 1'b0;
        mem_out    = 32'h0;
        if (mem_enable === 1'b1 && seen_en && sb.size() > 0) begin
            h = sb[0];
            if (h.lat >= 0 && wait_cnt == h.lat) begin
                mem_ready = 1'b1;
                mem_out   = h.rw ? h.rdata : 32'hBAD0_BAD0;
                mr_cyc    = cyc;
            end
            wait_cnt++;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            monitor_cycle();
        end
    endtask

    task automatic run_until_empty(input int bound);
        int k;
        k = 0;
        while (sb.size() > 0 && k < bound) begin
            tick();
            monitor_cycle();
            k++;
        end
        checkOutput("drain", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        i_strobe = 0; i_rw = 0; i_address = 0; i_data_in = 0;
        d_strobe = 0; d_rw = 0; d_address = 0; d_data_in = 0;
        mem_out = 0; mem_ready = 0;
        seq = 0; cont_n = 0; last_i_cyc = 0; last_d_cyc = 0;
        seen_en = 0; prev_ready = 0; exp_terr = 0;
        rep_i = 0; rep_d = 0; cont_mode = 0;
        tick();
        tick();
        check_all_zero("reset_state");
        reset = 1'b0;
        run_cycles(1);
        checkOutput("idle_after_reset", 32'(busy), 32'h0);

        // Tie after reset: D write first, then I read; grant_d goes 1 then 0.
        cyc0 = cyc;
        applyStimulus(1'b1, 1'b0, 32'h0000_0456, 32'h1234_5678, 32'h0, 0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_F123, 32'h0, 32'hCAFE_0001, 0);
        run_until_empty(30);
        checkOutput("tie_second_enable_cycle", 32'(last_en_cyc), 32'(cyc0 + 4));
        checkOutput("tie_second_owner_i", 32'(last_ready_d), 32'h0);
        run_cycles(2);

        // Lone D read, memory answers in cycle 3.
        cyc0 = cyc;
        applyStimulus(1'b1, 1'b1, 32'h0000_0ABC, 32'h0, 32'hDEAD_BEEF, 2);
        run_until_empty(30);
        checkOutput("lone_enable_cycle", 32'(last_en_cyc), 32'(cyc0 + 1));
        checkOutput("lone_ready_cycle", 32'(last_ready_cyc), 32'(cyc0 + 4));
        run_cycles(2);

        // Both requesters strobing continuously with 0-wait memory.
        cont_mode = 1'b1; rep_i = 1'b1; rep_d = 1'b1;
        next_request(1'b0);
        next_request(1'b1);
        run_cycles(24);
        rep_i = 1'b0; rep_d = 1'b0;
        run_until_empty(40);
        cont_mode = 1'b0;
        checkOutput("cont_served_enough", 32'(cont_n >= 6), 32'h1);
        run_cycles(2);

        // mem_ready on the very cycle the watchdog expires: normal completion.
        applyStimulus(1'b0, 1'b1, 32'h0000_0777, 32'h0, 32'h0ACE_CAFE, TIMEOUT);
        run_until_empty(30);
        checkOutput("expiry_race_no_error", 32'(timeout_error), 32'h0);
        run_cycles(2);

        // Memory never answers an I read: forced completion in cycle TIMEOUT+2.
        cyc0 = cyc;
        applyStimulus(1'b0, 1'b1, 32'h0000_0321, 32'h0, 32'h1111_2222, -1);
        run_until_empty(30);
        checkOutput("timeout_ready_at_6", 32'(last_ready_cyc), 32'(cyc0 + 6));
        checkOutput("timeout_error_set", 32'(timeout_error), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0888, 32'hA5A5_5A5A, 32'h0, 1);
        run_until_empty(30);
        run_cycles(1);
        checkOutput("timeout_error_sticky", 32'(timeout_error), 32'h1);

        // Stray mem_ready while idle must change nothing.
        run_cycles(1);
        mem_ready = 1'b1;
        mem_out   = 32'h7777_7777;
        run_cycles(1);
        checkOutput("stray_ready_idle_busy", 32'(busy), 32'h0);
        run_cycles(2);
        checkOutput("stray_ready_idle_enable", 32'(mem_enable), 32'h0);

        // Reset in the middle of a BUSY D read, then re-grant with D still strobing.
        applyStimulus(1'b1, 1'b1, 32'h0000_0ABC, 32'h0, 32'h5555_AAAA, 8);
        run_cycles(2);
        checkOutput("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        seen_en = 1'b0; prev_ready = 1'b0; mem_ready = 1'b0; exp_terr = 1'b0;
        tick();
        checkOutput("reset_no_d_ready", 32'(d_ready), 32'h0);
        check_all_zero("held_reset");
        reset = 1'b0;
        cyc0 = cyc;
        applyStimulus(1'b1, 1'b1, 32'h0000_0ABC, 32'h0, 32'h5555_AAAA, 0);
        run_until_empty(30);
        checkOutput("regrant_enable_cycle", 32'(last_en_cyc), 32'(cyc0 + 1));
        checkOutput("regrant_owner_d", 32'(last_ready_d), 32'h1);
        run_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
